fp_round_arbiter: RTL and testbench
===================================

FP_ROUND_ARBITER -- requirements
Module: fp_round_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one rounding datapath.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, biased exponent width.
REQ-003 SHALL have parameter FRAC_WIDTH, default 23, fraction width without hidden bit.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester valid.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester ready; at most one bit high per cycle.
REQ-008 SHALL have port req_sign  input  N_REQ  per-requester sign.
REQ-009 SHALL have port req_exp  input  N_REQ x EXP_WIDTH  per-requester biased exponent.
REQ-010 SHALL have port req_frac  input  N_REQ x (FRAC_WIDTH+3)  unrounded fraction; the low 3 bits are guard, round and sticky.
REQ-011 SHALL have port req_mode  input  N_REQ x 2  rounding mode, using the shared mode encodings.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer ready.
REQ-014 SHALL have ports out_sign (1), out_exp (EXP_WIDTH) and out_frac (FRAC_WIDTH), all outputs, carrying the rounded result.
REQ-015 SHALL have port out_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-016 SHALL have ports out_inexact (1) and out_overflow (1), both outputs, carrying the exception flags.

Function
REQ-017 SHALL be a two-stage pipeline: S1 holds the arbitrated, captured request; S2 holds the rounded result. Each stage has its own valid bit.
REQ-018 SHALL advance S2 when S2 is empty or out_valid and out_ready are both high; S1 SHALL advance when S2 advances or S1 is empty.
REQ-019 SHALL assert req_ready[i] only when requester i is granted and S1 is able to accept.
REQ-020 SHALL complete a handshake when req_valid[i] and req_ready[i] are both high; out_valid SHALL rise exactly 2 cycles after the handshake edge if there is no backpressure.
REQ-021 SHALL sustain 1 result per cycle while out_ready is held high.
REQ-022 SHALL arbitrate round-robin:
- search starts at the pointer, pointer = 0 after reset;
- after a handshake with requester i, pointer = (i+1) mod N_REQ;
- pointer SHALL NOT move when no handshake occurs.
REQ-023 SHALL make the grant depend only on req_valid and the pointer, never on req_ready; a valid request SHALL be served within N_REQ accepts.
REQ-024 SHALL hold S2 outputs stable while out_valid=1 and out_ready=0.
REQ-025 SHALL compute round_up per mode using guard, round and sticky (G/R/S) and the LSB:
- TONEAREST: round to nearest, ties to even;
- TOWARDZERO: never round up;
- DOWNWARD: round up if sign=1 and G|R|S;
- UPWARD: round up if sign=0 and G|R|S.
REQ-026 SHALL handle the rounding carry (mantissa overflow) as follows: out_frac = shifted sum, and out_exp = req_exp+1.
REQ-027 SHALL set out_inexact = G|R|S.
REQ-028 SHALL signal overflow when the post-carry exponent equals all-ones:
- set out_overflow=1;
- result is infinity (exp all-ones, frac 0) for TONEAREST, for DOWNWARD with sign=1, and for UPWARD with sign=0;
- otherwise result is max finite (exp all-ones minus 1, frac all-ones).
REQ-029 SHALL pass inputs with exponent all-ones (Inf/NaN) through unrounded: frac = upper FRAC_WIDTH bits, with out_inexact=0 and out_overflow=0.
REQ-030 SHALL pass a zero input (exp 0, frac 0) through as signed zero with both flags 0.

Reset
REQ-031 SHALL, while reset=1 (asynchronously):
- clear both valid bits and set the pointer to 0;
- drive all outputs to 0, including req_ready=0 and out_valid=0.
REQ-032 SHALL discard any in-flight request when reset asserts mid-operation; no result from it SHALL appear after reset deasserts.
REQ-033 SHALL accept its first request no earlier than the first rising edge after reset deasserts.

Structure
REQ-034 SHALL take the rounding-mode encodings (TONEAREST, TOWARDZERO, DOWNWARD, UPWARD) from the shared FloatingPointConsts definitions.
REQ-035 SHALL instantiate exactly one FloatingPointRound sub-module between S1 and S2 as the shared datapath.
REQ-036 SHALL keep arbitration, pipeline control and exception logic local to this module.

Verification
REQ-037 SHALL have directed tests covering the following scenarios:
- Scenario 1: requester 0, mode TONEAREST, sign 0, exp 0x80, frac {all-ones, 3'b100} -> after 2 cycles: carry, out_exp 0x81, out_frac 0, out_inexact 1, out_id 0.
- Scenario 2: all 4 req_valid held high, out_ready=1 -> grants in order 0,1,2,3,0; out_id follows the same order with one result per cycle.
- Scenario 3: exp 0xFE, frac all-ones with G=1:
  - mode TOWARDZERO -> exp 0xFE, frac all-ones, out_overflow 0, out_inexact 1;
  - mode UPWARD, sign 0 -> exp 0xFF, frac 0, out_overflow 1.
- Scenario 4: out_ready=0 for 5 cycles with 3 requests pending -> outputs stay stable; at most 2 requests are accepted; after release, results arrive in order with none lost.
- Scenario 5: reset asserted while S1 and S2 are full -> out_valid=0 immediately; no stale result appears after release; the pointer restarts at 0.
- Scenario 6: NaN input (exp 0xFF, nonzero frac) with mode UPWARD -> passes through with flags 0.

Source files
------------

// File: rtl/fp_round_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_round_arbiter_pkg
// Brief  : Rounding-mode encodings (FloatingPointConsts) and rounding helpers.
// Rev    : 1.0  initial release
// ============================================================================
package fp_round_arbiter_pkg;

  // Shared FloatingPointConsts rounding-mode encodings.
  typedef enum logic [1:0] {
    RM_TONEAREST  = 2'd0,
    RM_TOWARDZERO = 2'd1,
    RM_DOWNWARD   = 2'd2,
    RM_UPWARD     = 2'd3
  } round_mode_t;

  function automatic logic round_up_bit(input round_mode_t mode, input logic sign,
                                        input logic lsb, input logic g,
                                        input logic r, input logic s);
    logic inexact;
    inexact = g | r | s;
    case (mode)
      RM_TONEAREST:  round_up_bit = g & (r | s | lsb);
      RM_TOWARDZERO: round_up_bit = 1'b0;
      RM_DOWNWARD:   round_up_bit = sign & inexact;
      RM_UPWARD:     round_up_bit = ~sign & inexact;
      default:       round_up_bit = 1'b0;
    endcase
  endfunction

  // Modes whose overflow saturates to infinity rather than max finite.
  function automatic logic overflow_to_inf(input round_mode_t mode, input logic sign);
    overflow_to_inf = (mode == RM_TONEAREST) ||
                      (mode == RM_DOWNWARD && sign) ||
                      (mode == RM_UPWARD && !sign);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_arbiter_round.sv
`default_nettype none
// ============================================================================
// Module : fp_round_arbiter_round
// Brief  : Combinational FloatingPointRound datapath with exception flags.
// Rev    : 1.0  initial release
// ============================================================================
module fp_round_arbiter_round
  import fp_round_arbiter_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                  i_sign,
  input  logic [EXP_WIDTH-1:0]  i_exp,
  input  logic [FRAC_WIDTH+2:0] i_frac,
  input  round_mode_t           i_mode,
  output logic                  o_sign,
  output logic [EXP_WIDTH-1:0]  o_exp,
  output logic [FRAC_WIDTH-1:0] o_frac,
  output logic                  o_inexact,
  output logic                  o_overflow
);

  localparam logic [EXP_WIDTH-1:0] c_exp_ones       = '1;
  localparam logic [EXP_WIDTH-1:0] c_exp_max_finite = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

  logic                 w_up;
  logic [FRAC_WIDTH:0]  w_sum;
  logic                 w_carry;
  logic [EXP_WIDTH-1:0] w_exp_post;

  always_comb begin
    w_up       = round_up_bit(i_mode, i_sign, i_frac[3], i_frac[2], i_frac[1], i_frac[0]);
    w_sum      = {1'b0, i_frac[FRAC_WIDTH+2:3]} + {{FRAC_WIDTH{1'b0}}, w_up};
    w_carry    = w_sum[FRAC_WIDTH];
    w_exp_post = i_exp + {{(EXP_WIDTH-1){1'b0}}, w_carry};

    o_sign     = i_sign;
    o_exp      = w_exp_post;
    o_frac     = w_sum[FRAC_WIDTH-1:0];
    o_inexact  = |i_frac[2:0];
    o_overflow = 1'b0;

    // Inf/NaN inputs bypass rounding entirely.
    if (i_exp == c_exp_ones) begin
      o_exp     = i_exp;
      o_frac    = i_frac[FRAC_WIDTH+2:3];
      o_inexact = 1'b0;
    end else if (w_exp_post == c_exp_ones) begin
      o_overflow = 1'b1;
      if (overflow_to_inf(i_mode, i_sign)) begin
        o_frac = '0;
      end else begin
        o_exp  = c_exp_max_finite;
        o_frac = '1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_round_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fp_round_arbiter
// Brief  : Round-robin arbiter sharing one two-stage FP rounding pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module fp_round_arbiter
  import fp_round_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  localparam int ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0]                    req_sign,
  input  logic [N_REQ-1:0][EXP_WIDTH-1:0]     req_exp,
  input  logic [N_REQ-1:0][FRAC_WIDTH+2:0]    req_frac,
  input  logic [N_REQ-1:0][1:0]               req_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_sign,
  output logic [EXP_WIDTH-1:0]                out_exp,
  output logic [FRAC_WIDTH-1:0]               out_frac,
  output logic [ID_WIDTH-1:0]                 out_id,
  output logic                                out_inexact,
  output logic                                out_overflow
);

  logic [ID_WIDTH-1:0]   r_ptr;
  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic [EXP_WIDTH-1:0]  r_s1_exp;
  logic [FRAC_WIDTH+2:0] r_s1_frac;
  round_mode_t           r_s1_mode;
  logic [ID_WIDTH-1:0]   r_s1_id;

  logic                  r_s2_valid;
  logic                  r_out_sign;
  logic [EXP_WIDTH-1:0]  r_out_exp;
  logic [FRAC_WIDTH-1:0] r_out_frac;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic                  r_out_inexact;
  logic                  r_out_overflow;

  logic [ID_WIDTH-1:0]   w_cand [N_REQ];
  logic                  w_gnt_any;
  logic [ID_WIDTH-1:0]   w_gnt_idx;
  logic [ID_WIDTH-1:0]   w_ptr_next;
  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_hs;

  logic                  w_rnd_sign;
  logic [EXP_WIDTH-1:0]  w_rnd_exp;
  logic [FRAC_WIDTH-1:0] w_rnd_frac;
  logic                  w_rnd_inexact;
  logic                  w_rnd_overflow;

  // Candidate order starting at the pointer; grant never looks at req_ready.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_cand[k] = ID_WIDTH'((int'(r_ptr) + k) % N_REQ);
    end
  end

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_cand[k]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[k];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_WIDTH'(1);
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = w_s2_adv || !r_s1_valid;
  assign w_hs       = w_gnt_any && w_s1_adv;
  assign req_ready  = (w_hs && !reset) ? (N_REQ'(1) << w_gnt_idx) : '0;

  fp_round_arbiter_round #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_round (
    .i_sign     (r_s1_sign),
    .i_exp      (r_s1_exp),
    .i_frac     (r_s1_frac),
    .i_mode     (r_s1_mode),
    .o_sign     (w_rnd_sign),
    .o_exp      (w_rnd_exp),
    .o_frac     (w_rnd_frac),
    .o_inexact  (w_rnd_inexact),
    .o_overflow (w_rnd_overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr          <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_sign      <= 1'b0;
      r_s1_exp       <= '0;
      r_s1_frac      <= '0;
      r_s1_mode      <= RM_TONEAREST;
      r_s1_id        <= '0;
      r_s2_valid     <= 1'b0;
      r_out_sign     <= 1'b0;
      r_out_exp      <= '0;
      r_out_frac     <= '0;
      r_out_id       <= '0;
      r_out_inexact  <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_hs;
        if (w_hs) begin
          r_s1_sign <= req_sign[w_gnt_idx];
          r_s1_exp  <= req_exp[w_gnt_idx];
          r_s1_frac <= req_frac[w_gnt_idx];
          r_s1_mode <= round_mode_t'(req_mode[w_gnt_idx]);
          r_s1_id   <= w_gnt_idx;
        end
      end
      // Result registers only change on advance, so a stalled result is held.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_sign     <= w_rnd_sign;
          r_out_exp      <= w_rnd_exp;
          r_out_frac     <= w_rnd_frac;
          r_out_id       <= r_s1_id;
          r_out_inexact  <= w_rnd_inexact;
          r_out_overflow <= w_rnd_overflow;
        end
      end
      if (w_hs) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_sign     = r_out_sign;
  assign out_exp      = r_out_exp;
  assign out_frac     = r_out_frac;
  assign out_id       = r_out_id;
  assign out_inexact  = r_out_inexact;
  assign out_overflow = r_out_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_round_arbiter
// Brief  : Directed and randomized checks against an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_round_arbiter;
  import fp_round_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid, req_ready, req_sign;
  logic [3:0][7:0]  req_exp;
  logic [3:0][25:0] req_frac;
  logic [3:0][1:0]  req_mode;
  logic             out_valid, out_ready, out_sign, out_inexact, out_overflow;
  logic [7:0]       out_exp;
  logic [22:0]      out_frac;
  logic [1:0]       out_id;

  typedef struct packed {
    logic        v;
    logic [1:0]  id;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        inx;
    logic        ovf;
  } slot_t;

  slot_t m_s1, m_s2;
  int    m_ptr;
  bit    drop_on_hs;
  int    n_total = 0;
  int    n_pass  = 0;
  int    obs_gnt[$];
  int    obs_id[$];

  fp_round_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
    .req_exp(req_exp), .req_frac(req_frac), .req_mode(req_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac), .out_id(out_id),
    .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Rounding computed on the integer value of the kept fraction and its 3-bit remainder.
  function automatic slot_t ref_round(input bit s, input int e, input int f, input int m);
    slot_t r;
    int    keep, rem;
    bit    up, to_inf;
    r = '0; r.v = 1'b1; r.sign = s;
    if (e == 255) begin
      r.exp = 8'hFF; r.frac = 23'(f >> 3);
      return r;
    end
    keep  = f >> 3;
    rem   = f % 8;
    r.inx = (rem != 0);
    if (m == int'(RM_TONEAREST))     up = (rem > 4) || (rem == 4 && keep % 2 == 1);
    else if (m == int'(RM_DOWNWARD)) up = s && rem != 0;
    else if (m == int'(RM_UPWARD))   up = !s && rem != 0;
    else                             up = 1'b0;
    keep = keep + int'(up);
    if (keep == (1 << 23)) begin keep = 0; e = e + 1; end
    if (e == 255) begin
      r.ovf  = 1'b1;
      to_inf = (m == int'(RM_TONEAREST)) || (m == int'(RM_DOWNWARD) && s) || (m == int'(RM_UPWARD) && !s);
      if (to_inf) keep = 0;
      else begin e = 254; keep = (1 << 23) - 1; end
    end
    r.exp  = 8'(e);
    r.frac = 23'(keep);
    return r;
  endfunction

  task automatic set_req(input int i, input bit s, input logic [7:0] e,
                         input logic [25:0] f, input round_mode_t m);
    req_sign[i] = s; req_exp[i] = e; req_frac[i] = f; req_mode[i] = m; req_valid[i] = 1'b1;
  endtask

  task automatic set_rand(input int i);
    logic [7:0]  e;
    logic [25:0] f;
    case ($urandom_range(0, 7))
      0: e = 8'h00;  1: e = 8'hFF;  2: e = 8'hFE;  3: e = 8'h01;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 4))
      0: f = '0;
      1: f = '1;
      2: f = {23'h7FFFFF, 3'($urandom_range(0, 7))};
      default: f = 26'($urandom);
    endcase
    set_req(i, 1'($urandom), e, f, round_mode_t'($urandom_range(0, 3)));
  endtask

  // One clock: check at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    int         idx;
    bit         s2_adv, s1_adv, hs;
    logic [3:0] exp_rdy;
    slot_t      nslot;
    #4;
    idx = -1;
    for (int k = 0; k < 4; k++)
      if (idx < 0 && req_valid[(m_ptr + k) % 4]) idx = (m_ptr + k) % 4;
    s2_adv  = !m_s2.v || out_ready;
    s1_adv  = s2_adv || !m_s1.v;
    hs      = (idx >= 0) && s1_adv;
    exp_rdy = hs ? 4'(1 << idx) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_s2.v));
    if (m_s2.v) begin
      chk("out_id",       32'(out_id),       32'(m_s2.id));
      chk("out_sign",     32'(out_sign),     32'(m_s2.sign));
      chk("out_exp",      32'(out_exp),      32'(m_s2.exp));
      chk("out_frac",     32'(out_frac),     32'(m_s2.frac));
      chk("out_inexact",  32'(out_inexact),  32'(m_s2.inx));
      chk("out_overflow", 32'(out_overflow), 32'(m_s2.ovf));
    end
    for (int j = 0; j < 4; j++) if (req_ready[j]) obs_gnt.push_back(j);
    if (out_valid && out_ready) obs_id.push_back(int'(out_id));
    nslot = '0;
    if (hs) begin
      nslot    = ref_round(req_sign[idx], int'(req_exp[idx]), int'(req_frac[idx]), int'(req_mode[idx]));
      nslot.id = 2'(idx);
    end
    @(posedge clk); #1;
    if (s2_adv) m_s2 = m_s1;
    if (s1_adv) m_s1 = nslot;
    if (hs) begin
      m_ptr = (idx + 1) % 4;
      if (drop_on_hs) req_valid[idx] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_exp",   32'(out_exp),   32'd0);
    chk("rst_out_frac",  32'(out_frac),  32'd0);
    chk("rst_out_flags", 32'({out_inexact, out_overflow, out_sign, out_id}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    m_s1 = '0; m_s2 = '0; m_ptr = 0;
    obs_gnt.delete(); obs_id.delete();
  endtask

  initial begin
    int want[5];
    want = '{0, 1, 2, 3, 0};
    reset = 1'b1; out_ready = 1'b1; drop_on_hs = 1'b1;
    req_valid = '0; req_sign = '0; req_exp = '0; req_frac = '0; req_mode = '0;
    m_s1 = '0; m_s2 = '0; m_ptr = 0;
    @(posedge clk); #1;

    // Scenario 1: carry out of the mantissa on a tie-to-even round-up.
    do_reset();
    set_req(0, 1'b0, 8'h80, {23'h7FFFFF, 3'b100}, RM_TONEAREST);
    cycle(); cycle();
    chk("s1_valid",   32'(out_valid),   32'd1);
    chk("s1_exp",     32'(out_exp),     32'h81);
    chk("s1_frac",    32'(out_frac),    32'd0);
    chk("s1_inexact", 32'(out_inexact), 32'd1);
    chk("s1_id",      32'(out_id),      32'd0);
    cycle(); cycle();

    // Scenario 2: all requesters held valid, grants rotate.
    do_reset();
    drop_on_hs = 1'b0;
    for (int i = 0; i < 4; i++) set_rand(i);
    repeat (6) cycle();
    req_valid = '0;
    repeat (3) cycle();
    drop_on_hs = 1'b1;
    chk("s2_gnt_count", 32'(obs_gnt.size() >= 5), 32'd1);
    chk("s2_id_count",  32'(obs_id.size() >= 5),  32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < obs_gnt.size()) chk("s2_gnt_order", 32'(obs_gnt[k]), 32'(want[k]));
      if (k < obs_id.size())  chk("s2_id_order",  32'(obs_id[k]),  32'(want[k]));
    end

    // Scenario 3: max-exponent rounding, truncate vs. overflow to infinity.
    do_reset();
    set_req(0, 1'b0, 8'hFE, {23'h7FFFFF, 3'b100}, RM_TOWARDZERO);
    set_req(1, 1'b0, 8'hFE, {23'h7FFFFF, 3'b100}, RM_UPWARD);
    cycle(); cycle();
    chk("s3_tz_exp",  32'(out_exp),      32'hFE);
    chk("s3_tz_frac", 32'(out_frac),     32'h7FFFFF);
    chk("s3_tz_ovf",  32'(out_overflow), 32'd0);
    chk("s3_tz_inx",  32'(out_inexact),  32'd1);
    cycle();
    chk("s3_up_exp",  32'(out_exp),      32'hFF);
    chk("s3_up_frac", 32'(out_frac),     32'd0);
    chk("s3_up_ovf",  32'(out_overflow), 32'd1);
    cycle(); cycle();

    // Scenario 4: backpressure with three pending requests.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_rand(i);
    repeat (5) cycle();
    chk("s4_accepted", 32'(obs_gnt.size()), 32'd2);
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("s4_result_count", 32'(obs_id.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < obs_id.size()) chk("s4_result_order", 32'(obs_id[k]), 32'(k));

    // Scenario 5: reset with both stages full.
    do_reset();
    out_ready = 1'b0;
    set_rand(0); set_rand(1);
    cycle(); cycle();
    chk("s5_full_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("s5_no_stale", 32'(obs_id.size()), 32'd0);
    set_rand(1); set_rand(2); set_rand(0);
    cycle();
    chk("s5_first_grant", 32'(obs_gnt.size() > 0 ? obs_gnt[0] : -1), 32'd0);
    repeat (5) cycle();

    // Scenario 6: NaN passes through unrounded.
    do_reset();
    set_req(2, 1'b0, 8'hFF, {23'h400001, 3'b101}, RM_UPWARD);
    cycle(); cycle();
    chk("s6_exp",   32'(out_exp),   32'hFF);
    chk("s6_frac",  32'(out_frac),  32'h400001);
    chk("s6_flags", 32'({out_inexact, out_overflow}), 32'd0);
    chk("s6_id",    32'(out_id),    32'd2);
    cycle();

    // Randomized traffic with random backpressure.
    do_reset();
    repeat (400) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 2) != 0) set_rand(i);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
